// File: rtl/screen_state_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : screen_state_ctrl_if
// Description : Event inputs and screen-state outputs of the screen sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface screen_state_ctrl_if;
    logic       vblnk;
    logic       btn_start;
    logic       btn_pause;
    logic       game_over;
    logic       level_done;
    logic [5:0] state_bin;
    logic       frame_tick;
    logic       game_active;
    logic [3:0] level;

    modport master (
        output vblnk, btn_start, btn_pause, game_over, level_done,
        input  state_bin, frame_tick, game_active, level
    );

    modport slave (
        input  vblnk, btn_start, btn_pause, game_over, level_done,
        output state_bin, frame_tick, game_active, level
    );
endinterface

`default_nettype wire

// File: rtl/screen_state_ctrl.sv
//------------------------------------------------------------------------------
// Module      : screen_state_ctrl
// Description : Frame-synchronous game-screen sequencer; commits transitions at vblank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module screen_state_ctrl #(
    parameter int LEVEL_HOLD_FRAMES = 120,
    parameter int END_HOLD_FRAMES   = 180,
    parameter int MAX_LEVEL         = 9
) (
    input  wire logic          clk,
    input  wire logic          rst,
    screen_state_ctrl_if.slave bus
);

    localparam logic [5:0] c_ST_START = 6'b000001;
    localparam logic [5:0] c_ST_PLAY  = 6'b000010;
    localparam logic [5:0] c_ST_END   = 6'b000100;
    localparam logic [5:0] c_ST_LVLUP = 6'b010000;
    localparam logic [5:0] c_ST_PAUSE = 6'b100000;

    localparam int c_HOLD_MAX = (LEVEL_HOLD_FRAMES > END_HOLD_FRAMES) ?
                                LEVEL_HOLD_FRAMES : END_HOLD_FRAMES;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);

    localparam logic [c_HOLD_W-1:0] c_LVL_LAST = c_HOLD_W'(LEVEL_HOLD_FRAMES - 1);
    localparam logic [c_HOLD_W-1:0] c_END_LAST = c_HOLD_W'(END_HOLD_FRAMES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [3:0]          c_MAX_LVL  = 4'(MAX_LEVEL);

    logic                r_vblnk_d, r_vblnk_low_seen;
    logic                r_start_d, r_pause_d, r_over_d, r_lvl_d;
    logic                r_start_p, r_pause_p, r_over_p, r_lvl_p;
    logic                r_frame_tick;
    logic [5:0]          r_state;
    logic [3:0]          r_level;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_game_active;

    logic                w_start_ev, w_pause_ev, w_over_ev, w_lvl_ev;
    logic                w_start_any, w_pause_any, w_over_any, w_lvl_any;
    logic [5:0]          w_state_nxt;
    logic [3:0]          w_level_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_active_nxt;

    assign w_start_ev  = bus.btn_start  & ~r_start_d;
    assign w_pause_ev  = bus.btn_pause  & ~r_pause_d;
    assign w_over_ev   = bus.game_over  & ~r_over_d;
    assign w_lvl_ev    = bus.level_done & ~r_lvl_d;

    // An event landing in the tick cycle itself still takes part in that evaluation.
    assign w_start_any = r_start_p | w_start_ev;
    assign w_pause_any = r_pause_p | w_pause_ev;
    assign w_over_any  = r_over_p  | w_over_ev;
    assign w_lvl_any   = r_lvl_p   | w_lvl_ev;

    // Edge detect, frame tick and sticky pending flags.
    // The low-seen flag suppresses a false tick when vblnk is already high at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_d        <= 1'b0;
            r_vblnk_low_seen <= 1'b0;
            r_start_d        <= 1'b0;
            r_pause_d        <= 1'b0;
            r_over_d         <= 1'b0;
            r_lvl_d          <= 1'b0;
            r_start_p        <= 1'b0;
            r_pause_p        <= 1'b0;
            r_over_p         <= 1'b0;
            r_lvl_p          <= 1'b0;
            r_frame_tick     <= 1'b0;
        end else begin
            r_vblnk_d        <= bus.vblnk;
            r_vblnk_low_seen <= r_vblnk_low_seen | ~bus.vblnk;
            r_start_d        <= bus.btn_start;
            r_pause_d        <= bus.btn_pause;
            r_over_d         <= bus.game_over;
            r_lvl_d          <= bus.level_done;
            r_frame_tick     <= bus.vblnk & ~r_vblnk_d & r_vblnk_low_seen;
            if (r_frame_tick) begin
                r_start_p <= 1'b0;
                r_pause_p <= 1'b0;
                r_over_p  <= 1'b0;
                r_lvl_p   <= 1'b0;
            end else begin
                r_start_p <= w_start_any;
                r_pause_p <= w_pause_any;
                r_over_p  <= w_over_any;
                r_lvl_p   <= w_lvl_any;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_START;
            r_level       <= 4'd0;
            r_hold        <= '0;
            r_game_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_level       <= w_level_nxt;
            r_hold        <= w_hold_nxt;
            r_game_active <= w_active_nxt;
        end
    end

    // Next-state logic, evaluated only on the frame tick.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold;
        if (r_frame_tick) begin
            case (r_state)
                c_ST_START: begin
                    if (w_start_any) begin
                        w_state_nxt = c_ST_PLAY;
                        w_level_nxt = 4'd1;
                    end
                end
                c_ST_PLAY: begin
                    if (w_over_any) begin
                        w_state_nxt = c_ST_END;
                    end else if (w_lvl_any) begin
                        w_state_nxt = c_ST_LVLUP;
                        w_level_nxt = (r_level >= c_MAX_LVL) ? c_MAX_LVL : r_level + 4'd1;
                    end else if (w_pause_any) begin
                        w_state_nxt = c_ST_PAUSE;
                    end
                end
                c_ST_PAUSE: begin
                    if (w_pause_any || w_start_any) begin
                        w_state_nxt = c_ST_PLAY;
                    end
                end
                c_ST_LVLUP: begin
                    if (r_hold == c_LVL_LAST) begin
                        w_state_nxt = c_ST_PLAY;
                    end else begin
                        w_hold_nxt = r_hold + c_HOLD_ONE;
                    end
                end
                c_ST_END: begin
                    if (r_hold == c_END_LAST) begin
                        if (w_start_any) begin
                            w_state_nxt = c_ST_START;
                            w_level_nxt = 4'd0;
                        end
                    end else begin
                        w_hold_nxt = r_hold + c_HOLD_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_START;
                    w_level_nxt = 4'd0;
                end
            endcase
            if (w_state_nxt != r_state) begin
                w_hold_nxt = '0;
            end
        end
    end

    // Output logic.
    always_comb begin
        w_active_nxt    = (w_state_nxt == c_ST_PLAY);
        bus.state_bin   = r_state;
        bus.frame_tick  = r_frame_tick;
        bus.game_active = r_game_active;
        bus.level       = r_level;
    end

endmodule

`default_nettype wire

// File: tb/tb_screen_state_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_screen_state_ctrl
// Description : Frame-by-frame directed checks of the screen sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_screen_state_ctrl;

    localparam logic [5:0] ST_START = 6'b000001;
    localparam logic [5:0] ST_PLAY  = 6'b000010;
    localparam logic [5:0] ST_END   = 6'b000100;
    localparam logic [5:0] ST_LVLUP = 6'b010000;
    localparam logic [5:0] ST_PAUSE = 6'b100000;

    typedef struct {
        bit         s;
        bit         p;
        bit         o;
        bit         l;
        logic [5:0] st;
        logic [3:0] lv;
        bit         act;
    } vec_t;

    logic clk;
    logic rst;
    screen_state_ctrl_if bus ();

    int         checks;
    int         errors;
    logic [5:0] exp_prev;
    vec_t       vecs[24];

    screen_state_ctrl #(
        .LEVEL_HOLD_FRAMES (3),
        .END_HOLD_FRAMES   (4),
        .MAX_LEVEL         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_frame(input int idx, input vec_t v);
        bit ok;
        @(negedge clk);
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        bus.btn_start  = v.s;
        bus.btn_pause  = v.p;
        bus.game_over  = v.o;
        bus.level_done = v.l;
        @(negedge clk);
        bus.btn_start  = 1'b0;
        bus.btn_pause  = 1'b0;
        bus.game_over  = 1'b0;
        bus.level_done = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("row%0d_no_early", idx), bus.state_bin, exp_prev);
        bus.vblnk = 1'b1;
        wait_tick(ok);
        chk($sformatf("row%0d_tick_seen", idx), ok, 1);
        @(negedge clk);
        chk($sformatf("row%0d_state", idx), bus.state_bin, v.st);
        chk($sformatf("row%0d_level", idx), bus.level, v.lv);
        chk($sformatf("row%0d_active", idx), bus.game_active, v.act);
        chk($sformatf("row%0d_tick_1cyc", idx), bus.frame_tick, 0);
        exp_prev = v.st;
    endtask

    initial begin
        bit ok;
        int ticks;
        checks = 0;
        errors = 0;

        //            s  p  o  l  state     lv act
        vecs[0]  = '{1, 0, 0, 0, ST_PLAY,  1, 1};
        vecs[1]  = '{0, 1, 0, 0, ST_PAUSE, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, ST_PAUSE, 1, 0};
        vecs[3]  = '{0, 0, 0, 1, ST_PAUSE, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, ST_PAUSE, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, ST_PLAY,  1, 1};
        vecs[6]  = '{0, 0, 0, 0, ST_PLAY,  1, 1};
        vecs[7]  = '{0, 0, 0, 1, ST_LVLUP, 2, 0};
        vecs[8]  = '{0, 1, 0, 0, ST_LVLUP, 2, 0};
        vecs[9]  = '{0, 0, 0, 0, ST_LVLUP, 2, 0};
        vecs[10] = '{0, 0, 0, 0, ST_PLAY,  2, 1};
        vecs[11] = '{0, 0, 0, 1, ST_LVLUP, 2, 0};
        vecs[12] = '{0, 0, 0, 0, ST_LVLUP, 2, 0};
        vecs[13] = '{0, 0, 0, 0, ST_LVLUP, 2, 0};
        vecs[14] = '{0, 0, 0, 0, ST_PLAY,  2, 1};
        vecs[15] = '{0, 0, 1, 1, ST_END,   2, 0};
        vecs[16] = '{1, 0, 0, 0, ST_END,   2, 0};
        vecs[17] = '{1, 0, 0, 0, ST_END,   2, 0};
        vecs[18] = '{0, 0, 0, 0, ST_END,   2, 0};
        vecs[19] = '{0, 0, 0, 0, ST_END,   2, 0};
        vecs[20] = '{1, 0, 0, 0, ST_START, 0, 0};
        vecs[21] = '{0, 1, 0, 0, ST_START, 0, 0};
        vecs[22] = '{1, 0, 0, 0, ST_PLAY,  1, 1};
        vecs[23] = '{0, 0, 0, 1, ST_LVLUP, 2, 0};

        rst            = 1'b1;
        bus.vblnk      = 1'b0;
        bus.btn_start  = 1'b0;
        bus.btn_pause  = 1'b0;
        bus.game_over  = 1'b0;
        bus.level_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", bus.state_bin, ST_START);
        chk("rst_tick", bus.frame_tick, 0);
        chk("rst_active", bus.game_active, 0);
        chk("rst_level", bus.level, 0);
        rst = 1'b0;
        exp_prev = ST_START;

        for (int i = 0; i < 24; i++) begin
            do_frame(i, vecs[i]);
        end

        // Reset mid-frame while in LEVEL_UP.
        @(negedge clk);
        bus.vblnk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", bus.state_bin, ST_START);
        chk("midrst_level", bus.level, 0);
        chk("midrst_tick", bus.frame_tick, 0);
        chk("midrst_active", bus.game_active, 0);

        // vblnk high across reset release gives no tick until its next rising edge.
        bus.vblnk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        chk("held_vblnk_no_tick", ticks, 0);
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        bus.vblnk = 1'b1;
        wait_tick(ok);
        chk("held_vblnk_next_tick", ok, 1);

        // Start edge arriving in the tick cycle itself is used by that evaluation.
        bus.btn_start = 1'b1;
        @(negedge clk);
        bus.btn_start = 1'b0;
        chk("tickcyc_state", bus.state_bin, ST_PLAY);
        chk("tickcyc_level", bus.level, 1);
        chk("tickcyc_active", bus.game_active, 1);
        exp_prev = ST_PLAY;

        // A held pause level yields one event: PAUSE, then stays PAUSE next frame.
        @(negedge clk);
        bus.vblnk = 1'b0;
        bus.btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        bus.vblnk = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        chk("held_pause_1", bus.state_bin, ST_PAUSE);
        bus.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        bus.vblnk = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        chk("held_pause_2", bus.state_bin, ST_PAUSE);
        bus.btn_pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
